// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets four byte requesters share a single uart_send.
// Each grant owns one fixed-length frame slot, because uart_send has no busy flag.
module uart_tx_arbiter #(
  parameter int BIT_CYCLES = 10417,
  parameter int GAP_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  input  logic [3:0]  mask,
  output logic [3:0]  ack,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic [1:0]  grant_id
);

  localparam int FRAME_CYCLES = 10 * BIT_CYCLES + GAP_CYCLES;
  localparam int CNT_W        = $clog2(FRAME_CYCLES);
  // HOLD covers counter values 0 .. FRAME_CYCLES-2, i.e. FRAME_CYCLES-1 cycles.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(FRAME_CYCLES - 2);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       grant_id_q, grant_id_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0]       elig;
  logic [7:0]       req_bytes [4];
  logic             found;
  logic [1:0]       win;
  logic [1:0]       idx;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign req_bytes[gi] = req_data[8*gi +: 8];
      assign ack[gi]       = (state_q == ISSUE) && (grant_id_q == 2'(gi));
    end
  endgenerate

  assign elig     = req & mask;
  assign tx_valid = (state_q == ISSUE);
  assign busy     = (state_q != IDLE);
  assign tx_data  = tx_data_q;
  assign grant_id = grant_id_q;

  // Scan from ptr upward; iterating high-to-low lets the closest-to-ptr bit win.
  always_comb begin
    found = 1'b0;
    win   = 2'd0;
    idx   = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr_q + 2'(k);
      if (elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_id_d = grant_id_q;
    tx_data_d  = tx_data_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = ISSUE;
          tx_data_d  = req_bytes[win];
          grant_id_d = win;
          ptr_d      = win + 2'd1;
          cnt_d      = '0;
        end
      end
      ISSUE: state_d = HOLD;
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= 2'd0;
      grant_id_q <= 2'd0;
      tx_data_q  <= 8'h00;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_id_q <= grant_id_d;
      tx_data_q  <= tx_data_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one `uart_send` transmitter between four independent byte requesters using round-robin arbitration.
- `uart_send` exposes only `valid`/`data` and has no busy flag. This block therefore times each frame internally and issues at most one `valid` pulse per frame slot.
- Sits between string/message generators (e.g. ID-string senders, status reporters) and `uart_send`, in place of a single hard-wired sender.

Parameters:
- BIT_CYCLES, 10417, clk cycles per UART bit; must match `uart_send` (100 MHz / 9600 baud).
- GAP_CYCLES, 16, extra idle clk cycles appended after each 10-bit frame.
- FRAME_CYCLES (local, derived), 10*BIT_CYCLES+GAP_CYCLES, length of one transmit slot.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high; clock clk. Shared with `uart_send`.
- req  in  4  per-requester request level; bit i = requester i
- req_data  in  32  requester i byte on bits [8i+7:8i]; sampled only at grant
- mask  in  4  1 = requester enabled; 0 = requester ignored regardless of req
- ack  out  4  one-cycle pulse on the granted requester's bit
- tx_valid  out  1  one-cycle pulse to `uart_send.valid`
- tx_data  out  8  byte to `uart_send.data`; held stable until the next grant
- busy  out  1  high while a slot is in progress
- grant_id  out  2  index of the most recent grant; held between grants

Behaviour:
- Reset values:
  - ack=0, tx_valid=0, tx_data=0x00, busy=0, grant_id=0.
  - Round-robin pointer ptr=0; state=IDLE; slot counter=0.
- Eligible set: e = req & mask.
- States: IDLE, ISSUE, HOLD.
- IDLE:
  - If e==0: remain in IDLE.
  - Otherwise, select the winner i = first set bit of e scanning ptr, ptr+1, ... (mod 4).
  - Next edge registers: state=ISSUE, tx_data=req_data[i], grant_id=i, ptr=(i+1) mod 4, counter=0.
- ISSUE (exactly 1 cycle):
  - tx_valid=1, ack[i]=1, busy=1.
  - Next state: HOLD.
- HOLD:
  - tx_valid=0, ack=0, busy=1.
  - Counter increments every cycle.
  - Lasts exactly FRAME_CYCLES-1 cycles, then goes to IDLE.
- Slot timing:
  - busy is high for exactly FRAME_CYCLES cycles per grant.
  - Latency from the req edge (in IDLE) to ack/tx_valid: 1 clk.
  - With continuous requests, consecutive tx_valid pulses are exactly FRAME_CYCLES+1 clks apart (one IDLE arbitration cycle).
- Handshake:
  - req is a level and must be held until ack.
  - Requester holds req_data stable while req=1.
  - A requester may keep req high to request back-to-back bytes. Each ack consumes exactly one byte, and the requester updates req_data in the cycle after ack.
  - req deasserted before ack: the request is withdrawn and nothing is sent.
  - req and mask changes during ISSUE/HOLD are ignored until the next IDLE cycle.
- Fairness: after requester i is served it has lowest priority. Any continuously eligible requester is served within 4 slots.
- Simultaneous events: multiple eligible requesters in the same IDLE cycle are resolved solely by the ptr order; exactly one ack is issued.
- Reset mid-operation: all outputs drop to reset values immediately (async). The partial frame is abandoned (`uart_send` is reset by the same rst). After release, ptr=0.
- ack is one-hot or zero at all times; tx_valid==|ack in every cycle.
- Counter width: $clog2(FRAME_CYCLES) bits; no wrap occurs within a slot.

Test Plan:
- All tests override BIT_CYCLES=4, GAP_CYCLES=2, so FRAME_CYCLES=42.
- Reset: hold rst, drive random req/mask -> all outputs 0, tx_data=0x00, no ack for the whole reset period.
- Single request: mask=0xF, req=0b0100, req_data[23:16]=0x68 -> one clk later ack=0b0100, tx_valid=1, tx_data=0x68, grant_id=2; busy high exactly 42 clks; no further pulse after req drops on ack.
- Saturation: req=0xF held, bytes 0x41/0x42/0x43/0x44 -> grants in order 0,1,2,3,0; tx_data follows the same sequence; tx_valid spacing exactly 43 clks.
- Rotation: after a grant to 1, assert req=0b1001 in one cycle -> requester 3 is served before 0; grant_id=3 then 0.
- Masking: mask=0b1101, req=0b0011 -> only requester 0 is acked, repeatedly; requester 1 is never acked; set mask[1]=1 -> requester 1 is served in the next slot after the current one.
- Reset mid-HOLD: assert rst 10 clks into a slot -> busy and tx_valid drop immediately; after release, req=0b1001 -> grant_id=0 first.
